// File: rtl/param_code_lock_pkg.sv
// lock_pkg: state encoding and width helpers shared by the code-lock files.
package lock_pkg;

    typedef enum logic [2:0] {IDLE, ENTRY, UNLOCKED, LOCKOUT, PROGRAM} state_e;

    function automatic int btn_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/param_code_lock_btn_pulse.sv
// btn_pulse: two-flop synchroniser plus registered rising-edge one-shot for one raw button.
module btn_pulse
    import lock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic [2:0] sync_q;
    logic       pulse_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], btn_i};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/param_code_lock.sv
// param_code_lock: N_BTN-button CODE_LEN-step sequence lock with fail lockout and entry timeout.
// Defining LOCK_PROG_EN adds a PROGRAM state for rewriting the code while unlocked.
module param_code_lock
    import lock_pkg::*;
#(
    parameter int          N_BTN        = 4,
    parameter int          CODE_LEN     = 4,
    parameter logic [63:0] DEFAULT_CODE = 64'h3120,
    parameter int          MAX_FAILS    = 3,
    parameter int          LOCKOUT_CYC  = 1000,
    parameter int          TIMEOUT_CYC  = 500
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_BTN-1:0]                btn_in,
    input  logic                            prog,
    output logic                            is_unlocked,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   step_cnt,
    output logic [3:0]                      fail_cnt
);

    localparam int BW = btn_w(N_BTN);
    localparam int SW = $clog2(CODE_LEN + 1);
    localparam int CW = CODE_LEN * BW;
    localparam int TW = cnt_w((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC);

    logic [N_BTN-1:0] pulse;
    logic [BW-1:0]    idx;
    logic             any_press, single, hit, hit0, to_lock, timeout, lock_done;
    logic [CW-1:0]    code;
    logic [3:0]       fail_inc;
    state_e           st_q, st_d;
    logic [SW-1:0]    step_q, step_d;
    logic [3:0]       fail_q, fail_d;
    logic [TW-1:0]    tmr_q, tmr_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_pulse u_pulse (.clk(clk), .rst(rst), .btn_i(btn_in[i]), .pulse_o(pulse[i]));
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_BTN; i++) idx = pulse[i] ? BW'(i) : idx;
    end

`ifdef LOCK_PROG_EN
    logic [CW-1:0] code_q, code_d, prg_q, prg_d;
    assign code = code_q;
`else
    logic unused_prog;
    assign unused_prog = prog;
    assign code        = DEFAULT_CODE[CW-1:0];
`endif

    // More than one simultaneous pulse is a press, but never a matching one.
    assign any_press = |pulse;
    assign single    = any_press && ((pulse & (pulse - N_BTN'(1))) == '0);
    assign hit0      = single && (idx == code[0 +: BW]);
    assign hit       = single && (idx == code[int'(step_q) * BW +: BW]);
    assign fail_inc  = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    assign to_lock   = ({1'b0, fail_q} + 5'd1) == 5'(MAX_FAILS);
    assign timeout   = (TIMEOUT_CYC != 0) && (tmr_q == TW'(TIMEOUT_CYC - 1));
    assign lock_done = tmr_q == TW'(LOCKOUT_CYC - 1);

    always_comb begin
        st_d   = st_q;
        step_d = step_q;
        fail_d = fail_q;
        tmr_d  = (&tmr_q) ? tmr_q : tmr_q + TW'(1);
`ifdef LOCK_PROG_EN
        code_d = code_q;
        prg_d  = prg_q;
`endif
        case (st_q)
            IDLE: if (hit0) begin
                st_d   = (CODE_LEN == 1) ? UNLOCKED : ENTRY;
                step_d = SW'(1);
                fail_d = (CODE_LEN == 1) ? 4'd0 : fail_q;
            end
            ENTRY: if (hit) begin
                step_d = step_q + SW'(1);
                st_d   = (step_d == SW'(CODE_LEN)) ? UNLOCKED : ENTRY;
                fail_d = (step_d == SW'(CODE_LEN)) ? 4'd0 : fail_q;
            end else if (any_press || timeout) begin
                fail_d = fail_inc;
                st_d   = to_lock ? LOCKOUT : hit0 ? ENTRY : IDLE;
                step_d = (st_d == ENTRY) ? SW'(1) : '0;
            end
            UNLOCKED: begin
                if (any_press) begin
                    st_d   = hit0 ? ((CODE_LEN == 1) ? UNLOCKED : ENTRY) : IDLE;
                    step_d = hit0 ? SW'(1) : '0;
                end
`ifdef LOCK_PROG_EN
                if (prog) begin
                    st_d   = PROGRAM;
                    step_d = '0;
                end
`endif
            end
            LOCKOUT: if (lock_done) begin
                st_d   = IDLE;
                fail_d = '0;
            end
`ifdef LOCK_PROG_EN
            // New digits are staged so an aborted session leaves the live code untouched.
            PROGRAM: if ((any_press && !single) || timeout) begin
                st_d   = UNLOCKED;
                step_d = SW'(CODE_LEN);
            end else if (single) begin
                prg_d[int'(step_q) * BW +: BW] = idx;
                step_d = step_q + SW'(1);
                if (step_d == SW'(CODE_LEN)) begin
                    st_d   = IDLE;
                    step_d = '0;
                    code_d = prg_d;
                end
            end
`endif
            default: st_d = IDLE;
        endcase
        // Lockout must run its full length, so presses only clear the timer outside it.
        if (st_d != st_q || (any_press && st_q != LOCKOUT)) tmr_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= IDLE;
            step_q <= '0;
            fail_q <= '0;
            tmr_q  <= '0;
        end else begin
            st_q   <= st_d;
            step_q <= step_d;
            fail_q <= fail_d;
            tmr_q  <= tmr_d;
        end
    end

`ifdef LOCK_PROG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= DEFAULT_CODE[CW-1:0];
            prg_q  <= DEFAULT_CODE[CW-1:0];
        end else begin
            code_q <= code_d;
            prg_q  <= prg_d;
        end
    end
`endif

    assign is_unlocked = (st_q == UNLOCKED) || (st_q == PROGRAM);
    assign locked_out  = st_q == LOCKOUT;
    assign step_cnt    = step_q;
    assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_param_code_lock.sv
// tb_param_code_lock: directed presses queue expected output changes; a monitor checks each change.
module tb_param_code_lock;

    typedef struct {
        logic [8:0] o;
        int         lat;
        int         dt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_in = '0;
    logic       prog = 1'b0;
    logic       is_unlocked, locked_out;
    logic [2:0] step_cnt;
    logic [3:0] fail_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   press_cyc = 0;
    exp_t q[$];

    param_code_lock #(
        .N_BTN(4), .CODE_LEN(4), .DEFAULT_CODE(64'hD8),
        .MAX_FAILS(3), .LOCKOUT_CYC(40), .TIMEOUT_CYC(30)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .prog(prog),
        .is_unlocked(is_unlocked), .locked_out(locked_out),
        .step_cnt(step_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // lat: edges from the sampling edge of the last raw press (that edge counted as 0);
    // dt: edges since the previous output change; -1 skips either check.
    task automatic expect_out(input logic u, input logic l, input logic [2:0] s,
                              input logic [3:0] f, input int lat, input int dt);
        exp_t e;
        e.o   = {u, l, s, f};
        e.lat = lat;
        e.dt  = dt;
        q.push_back(e);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        btn_in    = m;
        press_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        btn_in = '0;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected changes still pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin : monitor
        logic [8:0] prev, cur;
        exp_t       e;
        bit         first;
        int         last_cyc;
        prev     = '0;
        first    = 1'b1;
        last_cyc = 0;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            cur = {is_unlocked, locked_out, step_cnt, fail_cnt};
            if (first || cur != prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur != e.o) begin
                        errors++;
                        $display("FAIL outputs: got %h required %h at cycle %0d", cur, e.o, cyc);
                    end
                    if (e.lat >= 0) begin
                        checks++;
                        if (cyc - press_cyc != e.lat) begin
                            errors++;
                            $display("FAIL latency: got %0d required %0d", cyc - press_cyc, e.lat);
                        end
                    end
                    if (e.dt >= 0) begin
                        checks++;
                        if (cyc - last_cyc != e.dt) begin
                            errors++;
                            $display("FAIL interval: got %0d required %0d", cyc - last_cyc, e.dt);
                        end
                    end
                end
                last_cyc = cyc;
                prev     = cur;
                first    = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        expect_out(0, 0, 0, 0, -1, -1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // Default code 0,2,1,3 unlocks; unlock shows on the 4th edge counting the sampling edge.
        expect_out(0, 0, 1, 0, 3, -1); press(4'b0001);
        expect_out(0, 0, 2, 0, 3, -1); press(4'b0100);
        expect_out(0, 0, 3, 0, 3, -1); press(4'b0010);
        expect_out(1, 0, 4, 0, 3, -1); press(4'b1000);
        drain(50);
        expect_out(0, 0, 0, 0, 3, -1); press(4'b0010);
        drain(50);
        // Wrong third step, then prefix-overlap restart.
        expect_out(0, 0, 1, 0, 3, -1); press(4'b0001);
        expect_out(0, 0, 2, 0, 3, -1); press(4'b0100);
        expect_out(0, 0, 0, 1, 3, -1); press(4'b1000);
        expect_out(0, 0, 1, 1, 3, -1); press(4'b0001);
        expect_out(0, 0, 1, 2, 3, -1); press(4'b0001);
        drain(50);
        // Buttons 1+2 together is the third failure; presses during lockout are ignored.
        expect_out(0, 1, 0, 3, 3, -1);
        expect_out(0, 0, 0, 0, -1, 40);
        press(4'b0110);
        press(4'b0001);
        press(4'b0100);
        press(4'b0010);
        drain(100);
        // Wrong press in IDLE ignored; inter-press timeout counts as a failure.
        press(4'b1000);
        expect_out(0, 0, 1, 0, 3, -1);
        expect_out(0, 0, 0, 1, -1, 30);
        press(4'b0001);
        drain(100);
        expect_out(0, 0, 1, 1, 3, -1); press(4'b0001);
        expect_out(0, 0, 2, 1, 3, -1); press(4'b0100);
        expect_out(0, 0, 3, 1, 3, -1); press(4'b0010);
        expect_out(1, 0, 4, 0, 3, -1); press(4'b1000);
        expect_out(0, 0, 1, 0, 3, -1); press(4'b0001);
        expect_out(0, 0, 0, 1, 3, -1); press(4'b0010);
        drain(50);
        // Reach lockout again, then reset asynchronously in the middle of it.
        expect_out(0, 0, 1, 1, 3, -1); press(4'b0001);
        expect_out(0, 0, 0, 2, 3, -1); press(4'b1000);
        expect_out(0, 0, 1, 2, 3, -1); press(4'b0001);
        expect_out(0, 1, 0, 3, 3, -1); press(4'b0001);
        drain(50);
        repeat (5) @(posedge clk);
        #2;
        expect_out(0, 0, 0, 0, -1, -1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain(10);
        // After reset the default code is back in force.
        expect_out(0, 0, 1, 0, 3, -1); press(4'b0001);
        expect_out(0, 0, 2, 0, 3, -1); press(4'b0100);
        expect_out(0, 0, 3, 0, 3, -1); press(4'b0010);
        expect_out(1, 0, 4, 0, 3, -1); press(4'b1000);
        drain(50);
`ifdef LOCK_PROG_EN
        expect_out(1, 0, 0, 0, -1, -1);
        @(negedge clk); prog = 1'b1;
        @(negedge clk); prog = 1'b0;
        drain(20);
        expect_out(1, 0, 1, 0, 3, -1); press(4'b1000);
        expect_out(1, 0, 2, 0, 3, -1); press(4'b1000);
        expect_out(1, 0, 3, 0, 3, -1); press(4'b0010);
        expect_out(0, 0, 0, 0, 3, -1); press(4'b0001);
        drain(50);
        press(4'b0001);
        press(4'b0100);
        expect_out(0, 0, 1, 0, 3, -1); press(4'b1000);
        expect_out(0, 0, 2, 0, 3, -1); press(4'b1000);
        expect_out(0, 0, 3, 0, 3, -1); press(4'b0010);
        expect_out(1, 0, 4, 0, 3, -1); press(4'b0001);
        drain(50);
`else
        @(negedge clk); prog = 1'b1;
        @(negedge clk); prog = 1'b0;
        repeat (5) @(negedge clk);
        expect_out(0, 0, 0, 0, 3, -1); press(4'b0010);
        drain(50);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
